// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : shared receiver FSM state encodings and parity mode constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ----------------------------------------------------------------------------
// uart_sync2 : two-flop synchronizer, resets to the idle-high line level
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg : configurable UART receiver with valid/ready word hand-off
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx_line,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int               IDX_W     = 4;
  localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_SLAST = IDX_W'(STOP_BITS - 1);

  logic                 line_s;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_q, ferr_d;
  logic                 deliver;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;
  logic                 perr_calc;
  logic                 data_xor;
  logic                 hs, accept, drop;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (i_rx_line),
    .q_o   (line_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  // Counter restarts at every sample point, so full-bit spacing is measured from the last sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    ferr_d    = ferr_q;
    deliver   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!line_s) begin
          state_d = ST_START;
          cnt_d   = '0;
          idx_d   = '0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = line_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IDX_W'(i)) shift_d[i] = line_s;
          end
          if (idx_q == IDX_DLAST) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          par_bit_d = line_s;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (!line_s) ferr_d = 1'b1;
          if (idx_q == IDX_SLAST) begin
            idx_d   = '0;
            state_d = ST_IDLE;
            deliver = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_xor = (^shift_q) ^ par_bit_q;

  always_comb begin
    perr_calc = 1'b0;
    if (PARITY == PAR_EVEN) begin
      perr_calc = data_xor;
    end else if (PARITY == PAR_ODD) begin
      perr_calc = ~data_xor;
    end
  end

  // A delivery colliding with a held word only lands if the held word leaves on this same edge.
  assign hs     = valid_q & i_ready;
  assign accept = deliver & (~valid_q | hs);
  assign drop   = deliver & valid_q & ~hs;

  always_comb begin
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_out_d = ferr_out_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    if (accept) begin
      data_d     = shift_q;
      perr_d     = perr_calc;
      ferr_out_d = ferr_d;
      valid_d    = 1'b1;
    end else if (hs) begin
      valid_d = 1'b0;
    end
    if (drop) begin
      ovr_d = 1'b1;
    end else if (hs) begin
      ovr_d = 1'b0;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_out_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_cfg : directed + random frames on 8N1, 8E1 and 7O2 receivers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n_v;
  logic [2:0] rx;
  logic [2:0] rdy;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] val, perr, ferr, ovr, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         rises [3] = '{0, 0, 0};
  int         vhigh [3] = '{0, 0, 0};
  int         cap_c [3] = '{0, 0, 0};
  logic [8:0] cap_d [3];
  logic [2:0] cap_p;
  logic [2:0] cap_f;
  logic [2:0] val_prev = 3'b000;
  logic [8:0] datv  [3];

  assign datv[0] = {1'b0, d0};
  assign datv[1] = {1'b0, d1};
  assign datv[2] = {2'b00, d2};

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n_v[0]), .i_rx_line(rx[0]), .o_data(d0), .o_valid(val[0]),
    .i_ready(rdy[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_overrun(ovr[0]),
    .o_busy(busy[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n_v[1]), .i_rx_line(rx[1]), .o_data(d1), .o_valid(val[1]),
    .i_ready(rdy[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_overrun(ovr[1]),
    .o_busy(busy[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n_v[2]), .i_rx_line(rx[2]), .o_data(d2), .o_valid(val[2]),
    .i_ready(rdy[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_overrun(ovr[2]),
    .o_busy(busy[2]));

  always @(posedge clk) cyc <= cyc + 1;

  // Records each o_valid rising edge with the word presented at that moment.
  always @(negedge clk) begin
    val_prev <= val;
    for (int k = 0; k < 3; k++) begin
      if (val[k]) vhigh[k] <= vhigh[k] + 1;
      if (val[k] && !val_prev[k]) begin
        rises[k] <= rises[k] + 1;
        cap_d[k] <= datv[k];
        cap_p[k] <= perr[k];
        cap_f[k] <= ferr[k];
        cap_c[k] <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_perr(input int pm, input logic [8:0] d, input int nb, input logic pb);
    int ones;
    ones = int'(pb);
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    if (pm == 1) return (ones % 2) != 0;
    if (pm == 2) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic exp_ferr(input logic [1:0] st, input int ns);
    for (int s = 0; s < ns; s++) if (!st[s]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic send_frame(input int k, input logic [8:0] d, input int nb, input int pm,
                            input logic pb, input logic [1:0] st, input int ns, output int t0);
    t0 = cyc;
    rx[k] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx[k] = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (pm != 0) begin
      rx[k] = pb;
      repeat (CPB) @(negedge clk);
    end
    for (int s = 0; s < ns; s++) begin
      rx[k] = st[s];
      repeat (CPB) @(negedge clk);
    end
    rx[k] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic run_frame(input int k, input logic [8:0] din, input logic pb,
                           input logic [1:0] st, input string tag, output int t0);
    int         nb;
    int         pm;
    int         ns;
    int         r0;
    int         h0;
    logic [8:0] d;
    nb = (k == 2) ? 7 : 8;
    pm = (k == 0) ? 0 : ((k == 1) ? 1 : 2);
    ns = (k == 2) ? 2 : 1;
    d  = din & 9'((1 << nb) - 1);
    r0 = rises[k];
    h0 = vhigh[k];
    send_frame(k, d, nb, pm, pb, st, ns, t0);
    chk({tag, ".delivered"}, 32'(rises[k] - r0), 32'd1);
    chk({tag, ".pulse"}, 32'(vhigh[k] - h0), 32'd1);
    chk({tag, ".data"}, 32'(cap_d[k]), 32'(d));
    chk({tag, ".perr"}, 32'(cap_p[k]), 32'(exp_perr(pm, d, nb, pb)));
    chk({tag, ".ferr"}, 32'(cap_f[k]), 32'(exp_ferr(st, ns)));
  endtask

  initial begin
    int         t0;
    int         r0;
    int         lat;
    logic [7:0] b7e;
    rst_n_v = 3'b000;
    rx      = 3'b111;
    rdy     = 3'b111;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d.valid", k), 32'(val[k]), 32'd0);
      chk($sformatf("rst%0d.busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst%0d.flags", k), 32'({ovr[k], perr[k], ferr[k]}), 32'd0);
      chk($sformatf("rst%0d.data", k), 32'(datv[k]), 32'd0);
    end
    rst_n_v = 3'b111;
    repeat (4) @(negedge clk);

    run_frame(0, 9'h0A5, 1'b0, 2'b11, "8n1_a5", t0);
    // Latency counted in edges from the first edge able to capture the start bit.
    lat = cap_c[0] - t0 - 1;
    chk("8n1_a5.latency_in_154pm1", 32'(lat >= 153 && lat <= 155), 32'd1);

    run_frame(1, 9'h003, 1'b1, 2'b11, "8e1_03_p1", t0);
    chk("8e1_03_p1.perr_set", 32'(cap_p[1]), 32'd1);
    run_frame(1, 9'h003, 1'b0, 2'b11, "8e1_03_p0", t0);
    run_frame(2, 9'h055, 1'b1, 2'b01, "7o2_55_stop2lo", t0);
    chk("7o2_55.ferr_set", 32'(cap_f[2]), 32'd1);

    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 3; k++) begin
        run_frame(k, 9'($urandom), 1'($urandom_range(0, 1)),
                  {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
                  $sformatf("rand%0d_%0d", n, k), t0);
      end
    end

    rdy[0] = 1'b0;
    r0 = rises[0];
    send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, t0);
    chk("ovr.first_valid", 32'(val[0]), 32'd1);
    chk("ovr.first_data", 32'(d0), 32'h11);
    chk("ovr.flag_clear", 32'(ovr[0]), 32'd0);
    send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1, t0);
    chk("ovr.held_data", 32'(d0), 32'h11);
    chk("ovr.flag_set", 32'(ovr[0]), 32'd1);
    chk("ovr.still_valid", 32'(val[0]), 32'd1);
    chk("ovr.one_rise", 32'(rises[0] - r0), 32'd1);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("ovr.valid_after_hs", 32'(val[0]), 32'd0);
    chk("ovr.flag_after_hs", 32'(ovr[0]), 32'd0);

    r0 = rises[0];
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch.busy_seen", 32'(busy[0]), 32'd1);
    @(negedge clk);
    rx[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch.back_idle", 32'(busy[0]), 32'd0);
    chk("glitch.no_valid", 32'(rises[0] - r0), 32'd0);

    b7e = 8'h7E;
    r0  = rises[0];
    rx[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx[0] = b7e[i];
      repeat (CPB) @(negedge clk);
    end
    rx[0] = b7e[3];
    repeat (CPB / 2) @(negedge clk);
    chk("midrst.busy_before", 32'(busy[0]), 32'd1);
    rst_n_v[0] = 1'b0;
    @(negedge clk);
    chk("midrst.busy_in_rst", 32'(busy[0]), 32'd0);
    chk("midrst.data_in_rst", 32'(d0), 32'd0);
    @(negedge clk);
    rst_n_v[0] = 1'b1;
    rx[0] = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    chk("midrst.no_delivery", 32'(rises[0] - r0), 32'd0);
    chk("midrst.idle", 32'(busy[0]), 32'd0);
    run_frame(0, 9'h07E, 1'b0, 2'b11, "midrst.next_7e", t0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clk cycles per bit period; legal values are 4 and above.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal values are 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values are 1..2.
REQ-005 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-006 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-007 i_rx_line  input  1  asynchronous serial line; idles high.
REQ-008 o_data  output  DATA_BITS  received word, LSB first on the line.
REQ-009 o_valid  output  1  o_data and error flags are valid.
REQ-010 i_ready  input  1  consumer accepts the word when o_valid and i_ready are both high on a clk edge.
REQ-011 o_parity_err  output  1  parity mismatch for the held word; always 0 when PARITY=0.
REQ-012 o_frame_err  output  1  at least one stop bit sampled low for the held word.
REQ-013 o_overrun  output  1  sticky flag: at least one frame was dropped since the last handshake.
REQ-014 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 i_rx_line SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized line only.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-017 IDLE -> START on the synchronized line low; the bit counter and bit index SHALL be cleared.
REQ-018 In START, the FSM counts (CLKS_PER_BIT-1)/2 cycles, then samples the line: low -> DATA with counter cleared; high -> IDLE (glitch rejected, no output).
REQ-019 In DATA, each bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1, measured from the previous sample point; bit i is stored at index i.
REQ-020 After DATA_BITS samples, the FSM SHALL go to PARITY if PARITY != 0, otherwise to STOP.
REQ-021 In PARITY, one bit SHALL be sampled; parity_err = (XOR of data bits ^ sampled bit) != 0 for even parity, and == 0 for odd parity.
REQ-022 In STOP, STOP_BITS samples SHALL be taken at full bit spacing; any low sample sets frame_err.
REQ-023 The FSM SHALL return to IDLE in the cycle after the final stop sample (mid-bit), so a start bit immediately after the stop bit is detected.
REQ-024 Word delivery SHALL happen at the clk edge after the final stop sample: if o_valid is 0, or a handshake occurs in that same cycle, o_data and both error flags load together and o_valid = 1.
REQ-025 If o_valid is 1 and no handshake occurs at delivery, the new frame SHALL be discarded, o_overrun set to 1, and the held word and flags left unchanged.
REQ-026 On a handshake with no simultaneous delivery, o_valid SHALL clear in the next cycle.
REQ-027 o_overrun SHALL clear on any handshake; if a handshake and a drop coincide, it SHALL end up set.
REQ-028 Errored frames SHALL still be delivered, with their error flags set; no frame is silently suppressed except by overrun.
REQ-029 The counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap within a bit period.

Reset
REQ-030 With rst_n low: state = IDLE, counters and index = 0, both synchronizer flops = 1, o_data = 0, all flags = 0, o_valid = 0, o_busy = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no delivery; after release, the receiver SHALL wait for a fresh falling edge.

Structure
REQ-032 A shared package uart_pkg SHALL hold the FSM state encodings and the PARITY mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-033 The synchronizer SHALL be a separate sub-module, uart_sync2, with async active-low reset to 1.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-034 8N1, send 0xA5, i_ready=1 -> o_data=0xA5, o_valid pulses 1 cycle, both error flags 0, delivery 2 sync + 8+16*9 cycles after the start edge (±1).
REQ-035 8E1, send 0x03 with parity bit 1 -> o_parity_err=1 and o_data=0x03; the same frame with parity bit 0 -> o_parity_err=0.
REQ-036 7O2, send 0x55 with the second stop bit driven low -> o_frame_err=1, o_data=0x55.
REQ-037 i_ready=0, send 0x11 then 0x22 -> o_data stays 0x11 and o_overrun=1; raise i_ready -> handshake, then o_valid=0 and o_overrun=0.
REQ-038 A 5-cycle low glitch in IDLE -> no o_valid, FSM back in IDLE; separately, pulse rst_n low during bit 3 of 0x7E -> no delivery, and the next 0x7E frame is received correctly.
